// File: rtl/ldst_cmd_sched.sv
// Load/store command scheduler.
// Queues load/store descriptors, splits each one into engine transfers of at
// most MAX_CHUNK lines and reports completion of the whole descriptor with
// its tag. The engine only ever sees 8-bit line counts.
module ldst_cmd_sched #(
    parameter int SDRAM_ADDR_W = 25,
    parameter int RF_ADDR_W    = 9,
    parameter int CMD_DEPTH    = 4,
    parameter int MAX_CHUNK    = 255,
    parameter int LINE_STRIDE  = 176,
    parameter int TAG_W        = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_is_store,
    input  logic [SDRAM_ADDR_W-1:0]       cmd_sdram_addr,
    input  logic [RF_ADDR_W-1:0]          cmd_rf_addr,
    input  logic [15:0]                   cmd_line_cnt,
    input  logic [TAG_W-1:0]              cmd_tag,
    output logic [SDRAM_ADDR_W-1:0]       ldst_sdram_addr,
    output logic [RF_ADDR_W-1:0]          ldst_rf_addr,
    output logic [7:0]                    ldst_line_num,
    output logic                          load_start,
    output logic                          store_start,
    input  logic                          ldst_done,
    output logic                          done_valid,
    output logic [TAG_W-1:0]              done_tag,
    output logic                          busy,
    output logic [$clog2(CMD_DEPTH):0]    queue_level
);

    localparam int PW     = $clog2(CMD_DEPTH);
    localparam int LW     = PW + 1;
    // chunk * stride is formed at full width before it meets the address adder
    localparam int PROD_W = 8 + $clog2(LINE_STRIDE);
    localparam logic [7:0] MAX_CHUNK_L = 8'(MAX_CHUNK);

    typedef struct packed {
        logic                    is_store;
        logic [SDRAM_ADDR_W-1:0] sdram;
        logic [RF_ADDR_W-1:0]    rf;
        logic [15:0]             cnt;
        logic [TAG_W-1:0]        tag;
    } desc_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_REPORT
    } state_t;

    // ------------------------------------------------------------------
    // Descriptor queue
    // ------------------------------------------------------------------
    desc_t           fifo_mem [CMD_DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [LW-1:0]   level_reg;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    desc_t           head;

    state_t                  state_reg;
    logic [SDRAM_ADDR_W-1:0] cur_sdram_reg;
    logic [RF_ADDR_W-1:0]    cur_rf_reg;
    logic [15:0]             remaining_reg;
    logic [7:0]              cur_chunk_reg;
    logic                    cur_store_reg;
    logic [TAG_W-1:0]        cur_tag_reg;
    logic                    load_start_reg;
    logic                    store_start_reg;
    logic                    done_valid_reg;
    logic [TAG_W-1:0]        done_tag_reg;

    logic [PROD_W-1:0]       step_bytes;
    logic [SDRAM_ADDR_W-1:0] sdram_next;
    logic [RF_ADDR_W-1:0]    rf_next;
    logic [7:0]              chunk_next;

    // Room is judged on the registered level alone, so a pop in the same
    // cycle never lets an extra push in.
    assign full  = (level_reg == LW'(CMD_DEPTH));
    assign empty = (level_reg == '0);
    assign push  = cmd_valid && !full;
    // The head stays queued while it is being worked on and leaves in REPORT.
    assign pop   = (state_reg == S_REPORT);
    // Small queue: combinational head read keeps the IDLE-to-start latency
    // at two cycles.
    assign head  = fifo_mem[rd_ptr_reg];

    // Queue storage write; no reset needed, validity lives in the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= '{is_store: cmd_is_store, sdram: cmd_sdram_addr,
                                      rf: cmd_rf_addr, cnt: cmd_line_cnt, tag: cmd_tag};
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Chunk arithmetic
    // ------------------------------------------------------------------
    assign step_bytes = PROD_W'(cur_chunk_reg) * PROD_W'(LINE_STRIDE);
    assign sdram_next = cur_sdram_reg + SDRAM_ADDR_W'(step_bytes);
    assign rf_next    = cur_rf_reg + RF_ADDR_W'(cur_chunk_reg);
    assign chunk_next = (remaining_reg > 16'(MAX_CHUNK)) ? MAX_CHUNK_L : remaining_reg[7:0];

    // Scheduler FSM with registered start/done pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            cur_sdram_reg   <= '0;
            cur_rf_reg      <= '0;
            remaining_reg   <= '0;
            cur_chunk_reg   <= '0;
            cur_store_reg   <= 1'b0;
            cur_tag_reg     <= '0;
            load_start_reg  <= 1'b0;
            store_start_reg <= 1'b0;
            done_valid_reg  <= 1'b0;
            done_tag_reg    <= '0;
        end else begin
            load_start_reg  <= 1'b0;
            store_start_reg <= 1'b0;
            done_valid_reg  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (!empty) begin
                        cur_store_reg <= head.is_store;
                        cur_sdram_reg <= head.sdram;
                        cur_rf_reg    <= head.rf;
                        remaining_reg <= head.cnt;
                        cur_tag_reg   <= head.tag;
                        state_reg     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (remaining_reg == 16'd0) begin
                        // done pulse lines up with the REPORT cycle
                        done_valid_reg <= 1'b1;
                        done_tag_reg   <= cur_tag_reg;
                        state_reg      <= S_REPORT;
                    end else begin
                        cur_chunk_reg   <= chunk_next;
                        load_start_reg  <= !cur_store_reg;
                        store_start_reg <= cur_store_reg;
                        state_reg       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    if (ldst_done) begin
                        remaining_reg <= remaining_reg - 16'(cur_chunk_reg);
                        cur_sdram_reg <= sdram_next;
                        cur_rf_reg    <= rf_next;
                        state_reg     <= S_CHECK;
                    end
                end
                S_REPORT: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready       = !full;
    assign ldst_sdram_addr = cur_sdram_reg;
    assign ldst_rf_addr    = cur_rf_reg;
    assign ldst_line_num   = cur_chunk_reg;
    assign load_start      = load_start_reg;
    assign store_start     = store_start_reg;
    assign done_valid      = done_valid_reg;
    assign done_tag        = done_tag_reg;
    assign busy            = (state_reg != S_IDLE) || !empty;
    assign queue_level     = level_reg;

endmodule

// File: tb/tb_ldst_cmd_sched.sv
// Directed bench for ldst_cmd_sched: descriptor table plus hand-written
// sequences for stray completions, a full queue and reset mid-transfer.
module tb_ldst_cmd_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_is_store = 1'b0;
    logic [24:0] cmd_sdram_addr = '0;
    logic [8:0]  cmd_rf_addr = '0;
    logic [15:0] cmd_line_cnt = '0;
    logic [3:0]  cmd_tag = '0;
    logic [24:0] ldst_sdram_addr;
    logic [8:0]  ldst_rf_addr;
    logic [7:0]  ldst_line_num;
    logic        load_start;
    logic        store_start;
    logic        ldst_done = 1'b0;
    logic        done_valid;
    logic [3:0]  done_tag;
    logic        busy;
    logic [2:0]  queue_level;

    always #5 clk = ~clk;

    ldst_cmd_sched dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_is_store    (cmd_is_store),
        .cmd_sdram_addr  (cmd_sdram_addr),
        .cmd_rf_addr     (cmd_rf_addr),
        .cmd_line_cnt    (cmd_line_cnt),
        .cmd_tag         (cmd_tag),
        .ldst_sdram_addr (ldst_sdram_addr),
        .ldst_rf_addr    (ldst_rf_addr),
        .ldst_line_num   (ldst_line_num),
        .load_start      (load_start),
        .store_start     (store_start),
        .ldst_done       (ldst_done),
        .done_valid      (done_valid),
        .done_tag        (done_tag),
        .busy            (busy),
        .queue_level     (queue_level)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    int n_load    = 0;
    int n_store   = 0;
    int n_done    = 0;
    int n_both    = 0;

    // pulse counters sampled on the active edge
    always @(posedge clk) begin
        if (load_start)  n_load++;
        if (store_start) n_store++;
        if (done_valid)  n_done++;
        if (load_start && store_start) n_both++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic st, input logic [24:0] sa, input logic [8:0] ra,
                        input logic [15:0] cnt, input logic [3:0] tg);
        cmd_is_store   = st;
        cmd_sdram_addr = sa;
        cmd_rf_addr    = ra;
        cmd_line_cnt   = cnt;
        cmd_tag        = tg;
        cmd_valid      = 1'b1;
        step();
        cmd_valid      = 1'b0;
    endtask

    // one-cycle engine completion, sampled on the next edge
    task automatic engine_done();
        ldst_done = 1'b1;
        step();
        ldst_done = 1'b0;
    endtask

    // wait (bounded) until more than 'target' load starts were counted
    task automatic wait_loads(input int target, output bit got);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (n_load > target) begin
                got = 1'b1;
                break;
            end
            step();
        end
    endtask

    typedef struct {
        logic        st;
        logic [24:0] sa;
        logic [8:0]  ra;
        logic [15:0] cnt;
        logic [3:0]  tag;
        int          stall;
        int          n_chunks;
        logic [24:0] f_sa;
        logic [8:0]  f_ra;
        logic [7:0]  f_num;
        logic [24:0] l_sa;
        logic [8:0]  l_ra;
        logic [7:0]  l_num;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bit got;
        int l0, s0, d0;

        // stride 176 B/line: 255 lines = 0xAF50, 510 lines = 0x15EA0
        vecs[0] = '{1'b0, 25'h100,     9'd3,   16'd10,  4'd5,  20, 1, 25'h100,     9'd3,   8'd10,  25'h100,   9'd3,   8'd10};
        vecs[1] = '{1'b1, 25'h0,       9'd0,   16'd600, 4'd2,  2,  3, 25'h0,       9'd0,   8'd255, 25'h15EA0, 9'd510, 8'd90};
        vecs[2] = '{1'b0, 25'h1FFFFF0, 9'd500, 16'd256, 4'd7,  1,  2, 25'h1FFFFF0, 9'd500, 8'd255, 25'hAF40,  9'd243, 8'd1};
        vecs[3] = '{1'b1, 25'h40,      9'd10,  16'd255, 4'hF,  3,  1, 25'h40,      9'd10,  8'd255, 25'h40,    9'd10,  8'd255};
        vecs[4] = '{1'b0, 25'h1234,    9'd511, 16'd1,   4'd1,  1,  1, 25'h1234,    9'd511, 8'd1,   25'h1234,  9'd511, 8'd1};
        vecs[5] = '{1'b0, 25'h555,     9'd7,   16'd0,   4'd9,  1,  0, 25'h0,       9'd0,   8'd0,   25'h0,     9'd0,   8'd0};
        vecs[6] = '{1'b0, 25'h0,       9'd0,   16'd510, 4'd3,  1,  2, 25'h0,       9'd0,   8'd255, 25'hAF50,  9'd255, 8'd255};

        // ---------------- reset state ----------------
        repeat (3) step();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_starts", {load_start, store_start}, 0);
        check("rst_done", done_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_level", queue_level, 0);
        rst_n = 1'b1;
        step();
        check("post_rst_outputs", {ldst_sdram_addr, ldst_rf_addr, ldst_line_num, done_tag}, 0);
        check("post_rst_ready", cmd_ready, 1);

        // ---------------- descriptor table ----------------
        for (int v = 0; v < 7; v++) begin
            l0 = n_load; s0 = n_store; d0 = n_done;
            push(vecs[v].st, vecs[v].sa, vecs[v].ra, vecs[v].cnt, vecs[v].tag);
            if (vecs[v].n_chunks == 0) begin
                step();
                check("zl_early_done", done_valid, 0);
                step();
                check("zl_done", done_valid, 1);
                check("zl_tag", done_tag, vecs[v].tag);
            end else begin
                step();
                check("start_early", {load_start, store_start}, 0);
                step();
                for (int c = 0; c < vecs[v].n_chunks; c++) begin
                    check("start_kind", {load_start, store_start}, vecs[v].st ? 2'b01 : 2'b10);
                    if (c == 0) begin
                        check("first_sdram", ldst_sdram_addr, vecs[v].f_sa);
                        check("first_rf", ldst_rf_addr, vecs[v].f_ra);
                        check("first_num", ldst_line_num, vecs[v].f_num);
                    end
                    if (c == vecs[v].n_chunks - 1) begin
                        check("last_sdram", ldst_sdram_addr, vecs[v].l_sa);
                        check("last_rf", ldst_rf_addr, vecs[v].l_ra);
                        check("last_num", ldst_line_num, vecs[v].l_num);
                    end
                    repeat (vecs[v].stall) step();
                    check("wait_hold", {load_start, store_start, done_valid}, 0);
                    // ldst_done cycle, then CHECK, then ISSUE/REPORT
                    engine_done();
                    step();
                end
                check("done_valid", done_valid, 1);
                check("done_tag", done_tag, vecs[v].tag);
            end
            step();
            check("done_pulse_len", done_valid, 0);
            check("idle_busy", busy, 0);
            check("n_starts", (n_load - l0) + (n_store - s0), vecs[v].n_chunks);
            check("n_done", n_done - d0, 1);
            $display("desc %0d: store=%0d lines=%0d tag=%0d chunks=%0d", v, vecs[v].st,
                     vecs[v].cnt, vecs[v].tag, vecs[v].n_chunks);
        end

        // ---------------- stray ldst_done in IDLE and ISSUE ----------------
        l0 = n_load; s0 = n_store; d0 = n_done;
        ldst_done = 1'b1;
        repeat (2) step();
        ldst_done = 1'b0;
        step();
        check("stray_idle_busy", busy, 0);
        check("stray_idle_pulses", (n_load - l0) + (n_store - s0) + (n_done - d0), 0);
        push(1'b0, 25'h300, 9'd20, 16'd300, 4'd6);
        repeat (2) step();
        check("stray_issue_start", load_start, 1);
        ldst_done = 1'b1;
        step();
        ldst_done = 1'b0;
        check("stray_issue_num", ldst_line_num, 255);
        repeat (3) step();
        check("stray_issue_no_restart", {load_start, done_valid, n_load - l0}, 1);
        engine_done();
        step();
        check("stray_chunk2_start", load_start, 1);
        check("stray_chunk2_num", ldst_line_num, 45);
        check("stray_chunk2_sdram", ldst_sdram_addr, 25'hB250);
        check("stray_chunk2_rf", ldst_rf_addr, 275);
        step();
        engine_done();
        step();
        check("stray_done_tag", {done_valid, done_tag}, {1'b1, 4'd6});
        step();
        $display("stray ldst_done sequence: tag 6, 300 lines");

        // ---------------- queue full ----------------
        l0 = n_load;
        for (int i = 0; i < 4; i++) begin
            push(1'b0, 25'(i * 32'h1000), 9'(i), 16'd5, 4'(i + 1));
        end
        check("full_ready", cmd_ready, 0);
        check("full_level", queue_level, 4);
        cmd_tag   = 4'hA;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        check("full_5th_rejected", queue_level, 4);
        for (int i = 0; i < 4; i++) begin
            wait_loads(l0 + i, got);
            check("full_start_seen", got, 1);
            check("full_num", ldst_line_num, 5);
            check("full_rf", ldst_rf_addr, i);
            engine_done();
            step();
            check("full_done_tag", {done_valid, done_tag}, {1'b1, 4'(i + 1)});
            if (i == 0) check("full_ready_in_report", cmd_ready, 0);
            step();
            if (i == 0) check("full_ready_after_pop", cmd_ready, 1);
            $display("queue-full completion %0d: tag %0d", i, done_tag);
        end
        repeat (10) step();
        check("full_no_extra", n_load - l0, 4);
        check("full_drained", {busy, queue_level}, 0);

        // ---------------- reset during WAIT ----------------
        l0 = n_load;
        push(1'b0, 25'h2000, 9'd100, 16'd300, 4'hC);
        wait_loads(l0, got);
        check("rstw_start_seen", got, 1);
        repeat (2) step();
        d0 = n_done;
        rst_n = 1'b0;
        #1;
        check("rstw_pulses", {load_start, store_start, done_valid}, 0);
        check("rstw_ready", cmd_ready, 1);
        check("rstw_busy_level", {busy, queue_level}, 0);
        check("rstw_ldst", {ldst_sdram_addr, ldst_rf_addr, ldst_line_num, done_tag}, 0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        check("rstw_no_done", n_done - d0, 0);
        check("rstw_idle", busy, 0);
        push(1'b0, 25'h200, 9'd0, 16'd300, 4'd3);
        repeat (2) step();
        check("rstw_new_start", load_start, 1);
        check("rstw_new_chunk1", {ldst_sdram_addr, ldst_rf_addr, ldst_line_num},
              {25'h200, 9'd0, 8'd255});
        step();
        engine_done();
        step();
        check("rstw_new_chunk2", {load_start, ldst_sdram_addr, ldst_rf_addr, ldst_line_num},
              {1'b1, 25'hB150, 9'd255, 8'd45});
        step();
        engine_done();
        step();
        check("rstw_new_done", {done_valid, done_tag}, {1'b1, 4'd3});
        step();
        $display("reset during WAIT: aborted tag 12, rerun tag 3");

        check("start_overlap", n_both, 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
